tick_stopwatch: RTL

Stopwatch core that consumes the free-running 1 Hz and 2 Hz square waves produced by the clock divider and turns them into an MM:SS BCD count. It treats the divided waves as asynchronous data, synchronizes them into `mclk`, edge-detects them into single-cycle enables, and runs a start/stop/clear control FSM. It sits between the divider and the 7-segment display driver and monitors the 1 Hz input for loss of ticks.

---
 rtl/stopwatch_pkg.sv | 39 +++
 rtl/tick_edge_sync.sv | 30 +++
 rtl/tick_stopwatch.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the tick_stopwatch core.
// The optional lap feature is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause
    } sw_state_e;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t min_tens;
        bcd_digit_t min_ones;
        bcd_digit_t sec_tens;
        bcd_digit_t sec_ones;
    } bcd_time_t;

    localparam bcd_digit_t SecOnesMax = 4'd9;
    localparam bcd_digit_t SecTensMax = 4'd5;
    localparam bcd_digit_t MinOnesMax = 4'd9;
    localparam bcd_digit_t MinTensMax = 4'd5;

    localparam int unsigned WD_LIMIT_DEFAULT = 1_200_000;
    localparam int unsigned WdWidth          = 21;

    // Returns {carry, next_digit}; any value at or above max wraps to zero.
    function automatic logic [4:0] bcd_inc(input bcd_digit_t d, input bcd_digit_t max);
        logic [4:0] res;
        if (d >= max) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, d + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Two-flop synchronizer plus delay flop for a slow divided wave, giving the
// synchronized level and a registered one-cycle rising-edge pulse.
module tick_edge_sync (
    input  logic mclk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q, sync_q, dly_q, rise_q;

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            rise_q <= sync_q & ~dly_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/tick_stopwatch.sv
// MM:SS BCD stopwatch driven by synchronized 1 Hz / 2 Hz divider waves, with a
// start/stop/clear FSM and a lost-tick watchdog. Lap capture: STOPWATCH_LAP_EN.
module tick_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned WD_LIMIT = WD_LIMIT_DEFAULT
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        clk_1hz_in,
    input  logic        clk_2hz_in,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic        running,
    output logic        sec_tick,
    output logic [15:0] time_bcd,
    output logic        ovf,
    output logic        blink,
    output logic        tick_lost
`ifdef STOPWATCH_LAP_EN
    ,
    input  logic        lap,
    output logic        lap_valid,
    output logic [15:0] lap_bcd
`endif
);

    localparam logic [WdWidth-1:0] WdLimit = WdWidth'(WD_LIMIT);

    logic lvl_1hz, rise_1hz, lvl_2hz, rise_2hz;

    tick_edge_sync u_sync_1hz (
        .mclk    (mclk),
        .rst_n   (rst_n),
        .async_i (clk_1hz_in),
        .level_o (lvl_1hz),
        .rise_o  (rise_1hz)
    );

    tick_edge_sync u_sync_2hz (
        .mclk    (mclk),
        .rst_n   (rst_n),
        .async_i (clk_2hz_in),
        .level_o (lvl_2hz),
        .rise_o  (rise_2hz)
    );

    // Only the 1 Hz edge and the 2 Hz level are consumed.
    logic unused_sync;
    assign unused_sync = lvl_1hz ^ rise_2hz;

    // ---------------- control FSM ----------------
    sw_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else if (stop) begin
            if (state_q == StRun) state_d = StPause;
        end else if (start) begin
            if (state_q != StRun) state_d = StRun;
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // ---------------- BCD counter ----------------
    bcd_time_t  time_q, time_d, time_inc;
    logic       ovf_q, ovf_d;
    logic       count_en;
    logic [4:0] so_n, st_n, mo_n, mt_n;
    logic       c_st, c_mo, c_mt, wrap;

    assign count_en = rise_1hz && (state_q == StRun) && !clear;

    always_comb begin
        so_n = bcd_inc(time_q.sec_ones, SecOnesMax);
        st_n = bcd_inc(time_q.sec_tens, SecTensMax);
        mo_n = bcd_inc(time_q.min_ones, MinOnesMax);
        mt_n = bcd_inc(time_q.min_tens, MinTensMax);

        c_st = so_n[4];
        c_mo = c_st & st_n[4];
        c_mt = c_mo & mo_n[4];
        wrap = c_mt & mt_n[4];

        time_inc.sec_ones = so_n[3:0];
        time_inc.sec_tens = c_st ? st_n[3:0] : time_q.sec_tens;
        time_inc.min_ones = c_mo ? mo_n[3:0] : time_q.min_ones;
        time_inc.min_tens = c_mt ? mt_n[3:0] : time_q.min_tens;
    end

    always_comb begin
        time_d = time_q;
        ovf_d  = ovf_q;
        if (clear) begin
            time_d = '0;
            ovf_d  = 1'b0;
        end else if (count_en) begin
            time_d = time_inc;
            if (wrap) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            time_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            time_q <= time_d;
            ovf_q  <= ovf_d;
        end
    end

    // ---------------- watchdog ----------------
    logic [WdWidth-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (rise_1hz) begin
            wd_d = '0;
        end else if (wd_q != {WdWidth{1'b1}}) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_d;
    end

    // ---------------- lap capture ----------------
`ifdef STOPWATCH_LAP_EN
    bcd_time_t lap_q, lap_d;
    logic      lap_valid_q, lap_valid_d;

    // Captures the pre-increment count, so a lap on a tick sees the old time.
    always_comb begin
        lap_d       = lap_q;
        lap_valid_d = lap_valid_q;
        if (clear) begin
            lap_d       = '0;
            lap_valid_d = 1'b0;
        end else if (lap && (state_q == StRun)) begin
            lap_d       = time_q;
            lap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign lap_valid = lap_valid_q;
    assign lap_bcd   = lap_q;
`endif

    // ---------------- outputs ----------------
    assign running   = (state_q == StRun);
    assign sec_tick  = rise_1hz;
    assign time_bcd  = time_q;
    assign ovf       = ovf_q;
    assign blink     = (state_q == StPause) ? lvl_2hz : 1'b1;
    assign tick_lost = (wd_q >= WdLimit);

endmodule
